// File: rtl/regfile_pkg.sv
// Shared constants and width helper for the multi-ported register file.
// Optional same-cycle write bypass is enabled by defining MP_REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRP_DEF   = 2;
    localparam int NWP_DEF   = 2;

    function automatic int aw_of(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/mp_regfile_sb.sv
// Register scoreboard: one pending bit per register.
// Priority: flush > reserve > write-clear > hold.
module mp_regfile_sb
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEF,
    parameter  int NWP   = NWP_DEF,
    localparam int AW    = aw_of(NREGS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    input  logic              flush,
    input  logic [NWP-1:0]    wr_en,
    input  logic [NWP*AW-1:0] wr_addr,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NWP; p++) begin
            if (wr_en[p]) begin
                busy_d[wr_addr[p*AW +: AW]] = 1'b0;
            end
        end
        // A same-cycle reserve means a newer producer is still in flight.
        if (rsv_en && rsv_addr != '0) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/mp_regfile.sv
// Multi-ported register file with scoreboard; x0 hardwired to zero.
// Define MP_REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module mp_regfile
    import regfile_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    parameter  int NRP   = NRP_DEF,
    parameter  int NWP   = NWP_DEF,
    localparam int AW    = aw_of(NREGS)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NRP*AW-1:0]   i_rp_addr,
    output logic [NRP*XLEN-1:0] o_rp_data,
    output logic [NRP-1:0]      o_rp_busy,
    input  logic [NWP-1:0]      i_wp_en,
    input  logic [NWP*AW-1:0]   i_wp_addr,
    input  logic [NWP*XLEN-1:0] i_wp_data,
    input  logic                i_rsv_en,
    input  logic [AW-1:0]       i_rsv_addr,
    input  logic                i_flush,
    output logic [NREGS-1:0]    o_busy_vec
);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] busy_vec;

    // Later ports overwrite earlier ones, so the highest port wins.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NWP; p++) begin
                if (i_wp_en[p] && i_wp_addr[p*AW +: AW] != '0) begin
                    mem[i_wp_addr[p*AW +: AW]] <= i_wp_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    mp_regfile_sb #(
        .NREGS (NREGS),
        .NWP   (NWP)
    ) u_sb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .rsv_en   (i_rsv_en),
        .rsv_addr (i_rsv_addr),
        .flush    (i_flush),
        .wr_en    (i_wp_en),
        .wr_addr  (i_wp_addr),
        .busy_vec (busy_vec)
    );

    assign o_busy_vec = busy_vec;

    for (genvar k = 0; k < NRP; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        logic            rb;

        assign ra = i_rp_addr[k*AW +: AW];

        always_comb begin
            rd = mem[ra];
            rb = busy_vec[ra];
`ifdef MP_REGFILE_BYPASS_EN
            for (int p = 0; p < NWP; p++) begin
                if (i_wp_en[p] && i_wp_addr[p*AW +: AW] == ra) begin
                    rd = i_wp_data[p*XLEN +: XLEN];
                    rb = i_rsv_en && (i_rsv_addr == ra);
                end
            end
`endif
            if (ra == '0) begin
                rd = '0;
                rb = 1'b0;
            end
        end

        assign o_rp_data[k*XLEN +: XLEN] = rd;
        assign o_rp_busy[k]              = rb;
    end

endmodule
